// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    localparam int PARCEL_W = 16;
    localparam int FQ_VA = 32;

    // Fetch PC after reset, halfword granular (bits VA-1:1)
    localparam logic [FQ_VA-1:1] FQ_RESET_PC = '0;

    // One queue entry: returned parcel plus the PC it was fetched from
    typedef struct packed {
        logic [PARCEL_W-1:0] parcel;
        logic [FQ_VA-1:1]    pc;
    } fq_entry_t;

    // Packed entry width for an arbitrary virtual address width
    function automatic int entry_width(input int va);
        return PARCEL_W + va - 1;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - small in-order FIFO with clear, used as the parcel queue
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occ
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Clear wins over both push and pop; pop on empty is a no-op
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Storage is write-only on push and is never reset; emptiness is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count holds 0..DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign occ       = count;
    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential parcel prefetch with credit-limited issue and redirect flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int             VA       = FQ_VA,
    parameter int             DEPTH    = 4,
    parameter int             MAXOUT   = 2,
    parameter logic [VA-1:1]  RESET_PC = FQ_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    output logic                req_valid,
    output logic [VA-1:1]       req_addr,
    input  logic                req_ready,
    input  logic                rsp_valid,
    input  logic [PARCEL_W-1:0] rsp_data,
    input  logic                redirect,
    input  logic [VA-1:1]       redirect_pc,
    output logic                iready,
    output logic [PARCEL_W-1:0] inst,
    output logic [VA-1:1]       inst_pc,
    input  logic                consume
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(MAXOUT + 1);
    localparam int EW = entry_width(VA);
    localparam logic [PW+1:0] DEPTH_LIM  = (PW+2)'(DEPTH);
    localparam logic [CW:0]   MAXOUT_LIM = (CW+1)'(MAXOUT);

    logic [VA-1:1]       fpc;
    logic [VA-1:1]       rpc;
    logic [CW-1:0]       live;
    logic [CW-1:0]       stale;
    logic [PW:0]         occ;
    logic                fifo_full;
    logic                fifo_empty;
    logic [EW-1:0]       head_data;
    logic [PARCEL_W-1:0] head_parcel;
    logic [VA-1:1]       head_pc;
    logic [PW+1:0]       credit_sum;
    logic [CW:0]         out_sum;
    logic                accept;
    logic                push;
    logic                pop;
    logic                rsp_stale;
    logic                redir_drop;

    // Queue slots already promised (filled + live in flight) and total memory requests in flight
    assign credit_sum = {1'b0, occ} + (PW+2)'(live);
    assign out_sum    = {1'b0, live} + {1'b0, stale};

    // Issue only when a queue slot is reserved for the reply and the memory has room
    assign req_valid = reset && !redirect && (credit_sum < DEPTH_LIM) && (out_sum < MAXOUT_LIM);
    assign req_addr  = fpc;
    assign accept    = req_valid && req_ready;

    // Responses drain stale (pre-redirect) requests first, then fill the queue
    assign push       = rsp_valid && !redirect && (stale == '0) && (live != '0);
    assign rsp_stale  = rsp_valid && !redirect && (stale != '0);
    assign redir_drop = rsp_valid && (out_sum != '0);
    assign pop        = consume && !fifo_empty && !redirect;

    // Fetch/response PCs and in-flight accounting; redirect turns all live requests stale
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            live  <= '0;
            stale <= '0;
        end else if (redirect) begin
            fpc   <= redirect_pc;
            rpc   <= redirect_pc;
            live  <= '0;
            stale <= redir_drop ? CW'(out_sum - (CW+1)'(1)) : CW'(out_sum);
        end else begin
            if (accept) begin
                fpc <= fpc + (VA-1)'(1);
            end
            if (push) begin
                rpc <= rpc + (VA-1)'(1);
            end
            case ({accept, push})
                2'b10:   live <= live + CW'(1);
                2'b01:   live <= live - CW'(1);
                default: live <= live;
            endcase
            if (rsp_stale) begin
                stale <= stale - CW'(1);
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({rsp_data, rpc}),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occ       (occ)
    );

    assign {head_parcel, head_pc} = head_data;

    // Head comes straight from registered storage; forced to zero while empty
    assign iready  = !fifo_empty;
    assign inst    = fifo_empty ? '0 : head_parcel;
    assign inst_pc = fifo_empty ? '0 : head_pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule
